// File: rtl/controle_acesso_memoria.sv
// Load/store access controller for the word-addressed data memory.
// Subword stores use read-modify-write; loads are lane-selected and extended.
module controle_acesso_memoria #(
    parameter int unsigned palavrasMemoria = 32
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [1:0]  reqSize,
    input  logic        reqSigned,
    input  logic [31:0] reqAddr,
    input  logic [31:0] reqWData,
    output logic        respValid,
    output logic [31:0] respData,
    output logic [1:0]  respErro,
    output logic [31:0] memAddress,
    output logic        memRead,
    output logic        memWrite,
    output logic [31:0] memWriteData,
    input  logic [31:0] memReadData
);

    typedef enum logic [1:0] {OCIOSO, LEITURA, ESCRITA, RESPOSTA} estado_t;

    localparam logic [31:0] LIMITE = 32'(palavrasMemoria);

    estado_t     estado, proximo;
    logic [31:0] addr_q, wdata_q, merge_q, dado_q;
    logic [1:0]  size_q, erro_q;
    logic        signed_q, write_q;

    logic        aceita, desalinhado, fora_faixa;
    logic [1:0]  erro_req;
    logic [7:0]  byte_sel;
    logic [15:0] meia_sel;
    logic [31:0] dado_fmt, dado_merge;

    assign aceita = reqValid && reqReady;

    // Misalignment wins over out-of-range
    always_comb begin
        desalinhado = (reqSize == 2'b11)
                   || (reqSize == 2'b01 && reqAddr[0])
                   || (reqSize == 2'b10 && reqAddr[1:0] != 2'b00);
        fora_faixa  = {2'b00, reqAddr[31:2]} >= LIMITE;
        erro_req    = desalinhado ? 2'b01 : (fora_faixa ? 2'b10 : 2'b00);
    end

    always_comb begin
        proximo = estado;
        unique case (estado)
            OCIOSO: begin
                if (aceita) begin
                    if (erro_req != 2'b00)
                        proximo = RESPOSTA;
                    else if (reqWrite && reqSize == 2'b10)
                        proximo = ESCRITA;
                    else
                        proximo = LEITURA;
                end
            end
            LEITURA:  proximo = write_q ? ESCRITA : RESPOSTA;
            ESCRITA:  proximo = RESPOSTA;
            RESPOSTA: proximo = OCIOSO;
        endcase
    end

    always_comb begin
        byte_sel = memReadData[{addr_q[1:0], 3'b000} +: 8];
        meia_sel = memReadData[{addr_q[1], 4'b0000} +: 16];
        case (size_q)
            2'b00:   dado_fmt = {{24{signed_q & byte_sel[7]}}, byte_sel};
            2'b01:   dado_fmt = {{16{signed_q & meia_sel[15]}}, meia_sel};
            default: dado_fmt = memReadData;
        endcase
    end

    always_comb begin
        dado_merge = merge_q;
        case (size_q)
            2'b00:   dado_merge[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'b01:   dado_merge[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: dado_merge = wdata_q;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            estado   <= OCIOSO;
            addr_q   <= '0;
            wdata_q  <= '0;
            merge_q  <= '0;
            dado_q   <= '0;
            size_q   <= '0;
            erro_q   <= '0;
            signed_q <= 1'b0;
            write_q  <= 1'b0;
        end else begin
            estado <= proximo;
            unique case (estado)
                OCIOSO: begin
                    if (aceita) begin
                        addr_q   <= reqAddr;
                        wdata_q  <= reqWData;
                        size_q   <= reqSize;
                        signed_q <= reqSigned;
                        write_q  <= reqWrite;
                        erro_q   <= erro_req;
                        dado_q   <= '0;
                    end
                end
                LEITURA: begin
                    if (write_q)
                        merge_q <= memReadData;
                    else
                        dado_q <= dado_fmt;
                end
                ESCRITA: ;
                RESPOSTA: begin
                    dado_q <= '0;
                    erro_q <= '0;
                end
            endcase
        end
    end

    always_comb begin
        reqReady     = (estado == OCIOSO);
        respValid    = (estado == RESPOSTA);
        respData     = dado_q;
        respErro     = erro_q;
        memRead      = (estado == LEITURA);
        memWrite     = (estado == ESCRITA);
        memAddress   = (memRead || memWrite) ? {2'b00, addr_q[31:2]} : 32'd0;
        memWriteData = memWrite ? dado_merge : 32'd0;
    end

endmodule

// File: tb/tb_controle_acesso_memoria.sv
// Directed bench for controle_acesso_memoria with a 32-word memory model.
module tb_controle_acesso_memoria;

    logic        clock = 1'b0;
    logic        resetN;
    logic        reqValid, reqReady, reqWrite, reqSigned;
    logic [1:0]  reqSize;
    logic [31:0] reqAddr, reqWData;
    logic        respValid;
    logic [31:0] respData;
    logic [1:0]  respErro;
    logic [31:0] memAddress, memWriteData;
    logic        memRead, memWrite;
    logic [31:0] memReadData = 32'd0;

    logic [31:0] mem [0:31];
    int vectors = 0;
    int miscompares = 0;
    int n_rd = 0, n_wr = 0, n_both = 0;
    int rd0, wr0;

    always #5 clock = ~clock;

    controle_acesso_memoria #(.palavrasMemoria(32)) dut (
        .clock(clock), .resetN(resetN),
        .reqValid(reqValid), .reqReady(reqReady),
        .reqWrite(reqWrite), .reqSize(reqSize),
        .reqSigned(reqSigned), .reqAddr(reqAddr),
        .reqWData(reqWData), .respValid(respValid),
        .respData(respData), .respErro(respErro),
        .memAddress(memAddress), .memRead(memRead),
        .memWrite(memWrite), .memWriteData(memWriteData),
        .memReadData(memReadData)
    );

    // Memory: reads sampled at negedge, writes commit at posedge
    always @(negedge clock) begin
        if (memRead) memReadData <= mem[memAddress[4:0]];
        if (memRead) n_rd++;
        if (memWrite) n_wr++;
        if (memRead && memWrite) n_both++;
    end

    always @(posedge clock)
        if (memWrite) mem[memAddress[4:0]] <= memWriteData;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic w, input logic [1:0] sz,
                         input logic sg, input logic [31:0] a,
                         input logic [31:0] d);
        reqValid = 1'b1; reqWrite = w; reqSize = sz;
        reqSigned = sg; reqAddr = a; reqWData = d;
        step();
        reqValid = 1'b0;
    endtask

    task automatic idle_check(input string tag);
        check({tag, "_ready"}, reqReady, 1);
        check({tag, "_rvalid_off"}, respValid, 0);
        check({tag, "_rdata_clr"}, respData, 0);
        check({tag, "_rerro_clr"}, respErro, 0);
    endtask

    task automatic do_load(input string tag, input logic [1:0] sz,
                           input logic sg, input logic [31:0] a,
                           input logic [31:0] exp);
        issue(1'b0, sz, sg, a, 32'd0);
        check({tag, "_memread"}, memRead, 1);
        check({tag, "_memaddr"}, memAddress, {2'b00, a[31:2]});
        step();
        check({tag, "_rvalid"}, respValid, 1);
        check({tag, "_rdata"}, respData, exp);
        check({tag, "_rerro"}, respErro, 0);
        step();
        idle_check(tag);
    endtask

    task automatic do_error(input string tag, input logic w,
                            input logic [1:0] sz, input logic [31:0] a,
                            input logic [1:0] exp);
        rd0 = n_rd; wr0 = n_wr;
        issue(w, sz, 1'b0, a, 32'hDEADBEEF);
        check({tag, "_rvalid"}, respValid, 1);
        check({tag, "_rerro"}, respErro, exp);
        check({tag, "_rdata"}, respData, 0);
        check({tag, "_strobes"}, {memRead, memWrite}, 0);
        step();
        idle_check(tag);
        check({tag, "_no_rd"}, n_rd - rd0, 0);
        check({tag, "_no_wr"}, n_wr - wr0, 0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'd0;
        mem[1] = 32'h00000004;
        mem[2] = 32'h80FF1234;
        resetN = 1'b0; reqValid = 1'b0; reqWrite = 1'b0;
        reqSize = 2'b00; reqSigned = 1'b0;
        reqAddr = 32'd0; reqWData = 32'd0;
        step(); step();
        idle_check("reset");
        check("reset_memread", memRead, 0);
        check("reset_memwrite", memWrite, 0);
        check("reset_memaddr", memAddress, 0);
        check("reset_memwdata", memWriteData, 0);
        resetN = 1'b1;
        step();

        // lw 0x04; a request held during RESPOSTA must not be taken
        issue(1'b0, 2'b10, 1'b0, 32'h04, 32'd0);
        check("lw_memread", memRead, 1);
        check("lw_ready_low", reqReady, 0);
        step();
        check("lw_rvalid", respValid, 1);
        check("lw_rdata", respData, 32'h00000004);
        check("lw_rerro", respErro, 0);
        check("lw_memread_once", memRead, 0);
        reqValid = 1'b1;
        step();
        check("b2b_not_taken_ready", reqReady, 1);
        check("b2b_not_taken_rd", memRead, 0);
        check("b2b_rdata_clr", respData, 0);
        step();
        reqValid = 1'b0;
        check("b2b_taken_rd", memRead, 1);
        step();
        check("b2b_rdata", respData, 32'h00000004);
        step();

        do_load("lb_s", 2'b00, 1'b1, 32'h0B, 32'hFFFFFF80);
        do_load("lbu", 2'b00, 1'b0, 32'h0B, 32'h00000080);
        do_load("lh_s", 2'b01, 1'b1, 32'h0A, 32'hFFFF80FF);
        do_load("lhu_lo", 2'b01, 1'b0, 32'h08, 32'h00001234);

        // sb 0x09: read, merge, write
        rd0 = n_rd; wr0 = n_wr;
        issue(1'b1, 2'b00, 1'b0, 32'h09, 32'h000000AB);
        check("sb_memread", memRead, 1);
        check("sb_nowrite_yet", memWrite, 0);
        step();
        check("sb_memwrite", memWrite, 1);
        check("sb_memread_off", memRead, 0);
        check("sb_wdata", memWriteData, 32'h80FFAB34);
        check("sb_waddr", memAddress, 32'd2);
        step();
        check("sb_rvalid", respValid, 1);
        check("sb_rdata", respData, 0);
        check("sb_rerro", respErro, 0);
        step();
        check("sb_rd_pulses", n_rd - rd0, 1);
        check("sb_wr_pulses", n_wr - wr0, 1);
        do_load("lw_after_sb", 2'b10, 1'b0, 32'h08, 32'h80FFAB34);

        do_error("lh_mis", 1'b0, 2'b01, 32'h03, 2'b01);
        do_error("size11", 1'b0, 2'b11, 32'h00, 2'b01);
        do_error("sw_oor", 1'b1, 2'b10, 32'h80, 2'b10);
        do_error("sw_mis_oor", 1'b1, 2'b10, 32'h82, 2'b01);

        // sw to the last word
        issue(1'b1, 2'b10, 1'b0, 32'h7C, 32'hDEADBEEF);
        check("sw_memwrite", memWrite, 1);
        check("sw_memread_off", memRead, 0);
        check("sw_waddr", memAddress, 32'd31);
        check("sw_wdata", memWriteData, 32'hDEADBEEF);
        step();
        check("sw_rvalid", respValid, 1);
        check("sw_word31", mem[31], 32'hDEADBEEF);
        step();
        do_load("lw_word31", 2'b10, 1'b0, 32'h7C, 32'hDEADBEEF);

        // sh 0x06 aborted by reset during ESCRITA
        issue(1'b1, 2'b01, 1'b0, 32'h06, 32'h00005555);
        check("sh_memread", memRead, 1);
        step();
        check("sh_memwrite", memWrite, 1);
        check("sh_wdata", memWriteData, 32'h55550004);
        #2 resetN = 1'b0;
        #1;
        check("abort_memwrite", memWrite, 0);
        check("abort_memread", memRead, 0);
        check("abort_memaddr", memAddress, 0);
        check("abort_memwdata", memWriteData, 0);
        idle_check("abort");
        step();
        check("abort_word1", mem[1], 32'h00000004);
        check("abort_no_resp", respValid, 0);
        resetN = 1'b1;
        step();
        do_load("lw_after_abort", 2'b10, 1'b0, 32'h04, 32'h00000004);

        check("never_both_strobes", n_both, 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
